// File: rtl/serial_decoder_pkg.sv
// Shared types and defaults for the serial-to-parallel frame decoder.
package serial_decoder_pkg;

  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned LSB_FIRST_DEF = 1;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter width able to hold 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/decoder_bit_counter.sv
// Frame bit index counter: load-to-1 on frame start, clear, increment, terminal at WIDTH-1.
module decoder_bit_counter
  import serial_decoder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  localparam int unsigned CW   = cnt_width(WIDTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          term_c
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CW'(1);
    end else if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_c  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_decoder.sv
// Deserializer: assembles strobed serial bits into WIDTH-bit words on a valid/ready output.
module serial_decoder
  import serial_decoder_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned LSB_FIRST = LSB_FIRST_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             clear_overrun,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  logic [CW-1:0]    count;
  logic             term;
  logic             cnt_load, cnt_clear, cnt_inc;
  logic             start, complete;
  logic [CW-1:0]    bit_idx, pos;
  logic [WIDTH-1:0] mask, base, word;

  decoder_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (cnt_load),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .count_o (count),
    .term_c  (term)
  );

  // Next-state, assembly, handshake and overrun logic.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    cnt_load    = 1'b0;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    complete    = 1'b0;

    start   = serial_valid && frame_start;
    bit_idx = start ? '0 : count;
    pos     = (LSB_FIRST != 0) ? bit_idx : CW'(WIDTH - 1) - bit_idx;
    mask    = WIDTH'(1) << pos;
    base    = start ? '0 : shift_q;
    word    = serial_in ? (base | mask) : (base & ~mask);

    unique case (state_q)
      HUNT: begin
        if (start) begin
          shift_d  = word;
          cnt_load = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // A frame_start always resyncs, even on what would be the final bit.
        if (start) begin
          shift_d  = word;
          cnt_load = 1'b1;
        end else if (serial_valid) begin
          if (term) begin
            complete  = 1'b1;
            shift_d   = '0;
            cnt_clear = 1'b1;
            state_d   = HUNT;
          end else begin
            shift_d = word;
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (clear_overrun) begin
      overrun_d = 1'b0;
    end

    // A stalled pending word wins over a new completion; the new word is dropped.
    if (complete) begin
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        out_d       = word;
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      shift_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign parallel_out = out_q;
  assign out_valid    = out_valid_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_serial_decoder.sv
// Directed bench for serial_decoder: LSB-first and MSB-first instances share one stimulus stream.
module tb_serial_decoder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       serial_in, serial_valid, frame_start, out_ready, clear_overrun;
  logic [7:0] pout_l, pout_m;
  logic       valid_l, valid_m, ovr_l, ovr_m, busy_l, busy_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  serial_decoder #(.WIDTH(8), .LSB_FIRST(1)) dut_lsb (
    .clock         (clock),
    .reset_n       (reset_n),
    .serial_in     (serial_in),
    .serial_valid  (serial_valid),
    .frame_start   (frame_start),
    .out_ready     (out_ready),
    .clear_overrun (clear_overrun),
    .parallel_out  (pout_l),
    .out_valid     (valid_l),
    .overrun       (ovr_l),
    .busy          (busy_l)
  );

  serial_decoder #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
    .clock         (clock),
    .reset_n       (reset_n),
    .serial_in     (serial_in),
    .serial_valid  (serial_valid),
    .frame_start   (frame_start),
    .out_ready     (out_ready),
    .clear_overrun (clear_overrun),
    .parallel_out  (pout_m),
    .out_valid     (valid_m),
    .overrun       (ovr_m),
    .busy          (busy_m)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Full frame, frame_start on bit 0; three idle cycles after bits gap_a/gap_b.
  task automatic send_word(input logic [7:0] w, input int gap_a, input int gap_b, input logic rdy_last);
    for (int k = 0; k < 8; k++) begin
      serial_valid = 1'b1;
      serial_in    = w[3'(k)];
      frame_start  = (k == 0);
      if (k == 7) out_ready = rdy_last;
      step();
      serial_valid = 1'b0;
      frame_start  = 1'b0;
      if (k == gap_a || k == gap_b) begin
        for (int g = 0; g < 3; g++) begin
          step();
          check_eq("gap_busy", 32'(busy_l), 32'd1);
        end
      end
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic fs_first);
    for (int k = 0; k < n; k++) begin
      serial_valid = 1'b1;
      serial_in    = b[3'(k)];
      frame_start  = fs_first && (k == 0);
      step();
    end
    serial_valid = 1'b0;
    frame_start  = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    serial_in     = 1'b0;
    serial_valid  = 1'b0;
    frame_start   = 1'b0;
    out_ready     = 1'b0;
    clear_overrun = 1'b0;
    #12;
    check_eq("rst_pout",  32'(pout_l),  32'h0);
    check_eq("rst_valid", 32'(valid_l), 32'h0);
    check_eq("rst_ovr",   32'(ovr_l),   32'h0);
    check_eq("rst_busy",  32'(busy_l),  32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // 1: always-ready consumer
    out_ready = 1'b1;
    send_word(8'hA5, -1, -1, 1'b1);
    check_eq("t1_pout",  32'(pout_l),  32'hA5);
    check_eq("t1_valid", 32'(valid_l), 32'h1);
    check_eq("t1_ovr",   32'(ovr_l),   32'h0);
    check_eq("t1_busy",  32'(busy_l),  32'h0);
    step();
    check_eq("t1_valid_drop", 32'(valid_l), 32'h0);
    check_eq("t1_pout_hold",  32'(pout_l),  32'hA5);

    // 2: gapped bits
    send_word(8'h3C, 2, 5, 1'b1);
    check_eq("t2_pout",  32'(pout_l),  32'h3C);
    check_eq("t2_valid", 32'(valid_l), 32'h1);
    step();
    check_eq("t2_valid_drop", 32'(valid_l), 32'h0);

    // 3: back-pressure and overrun
    out_ready = 1'b0;
    send_word(8'h11, -1, -1, 1'b0);
    check_eq("t3_pout_a",  32'(pout_l),  32'h11);
    check_eq("t3_valid_a", 32'(valid_l), 32'h1);
    check_eq("t3_ovr_a",   32'(ovr_l),   32'h0);
    send_word(8'h22, -1, -1, 1'b0);
    check_eq("t3_pout_b",  32'(pout_l),  32'h11);
    check_eq("t3_valid_b", 32'(valid_l), 32'h1);
    check_eq("t3_ovr_b",   32'(ovr_l),   32'h1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check_eq("t3_ovr_clr",   32'(ovr_l),   32'h0);
    check_eq("t3_valid_clr", 32'(valid_l), 32'h1);
    out_ready = 1'b1;
    step();
    check_eq("t3_valid_xfer", 32'(valid_l), 32'h0);
    check_eq("t3_pout_xfer",  32'(pout_l),  32'h11);

    // 4: completion coinciding with transfer
    out_ready = 1'b0;
    send_word(8'h55, -1, -1, 1'b0);
    check_eq("t4_pout_a", 32'(pout_l), 32'h55);
    send_word(8'hAA, -1, -1, 1'b1);
    check_eq("t4_valid", 32'(valid_l), 32'h1);
    check_eq("t4_pout",  32'(pout_l),  32'hAA);
    check_eq("t4_ovr",   32'(ovr_l),   32'h0);
    step();
    check_eq("t4_valid_drop", 32'(valid_l), 32'h0);

    // 5: resync mid-frame, stalled consumer exposes any stray completion
    out_ready = 1'b0;
    send_bits(8'h0F, 4, 1'b1);
    send_word(8'hF0, -1, -1, 1'b0);
    check_eq("t5_pout",  32'(pout_l),  32'hF0);
    check_eq("t5_valid", 32'(valid_l), 32'h1);
    check_eq("t5_ovr",   32'(ovr_l),   32'h0);
    out_ready = 1'b1;
    step();
    // resync landing on the would-be final bit
    out_ready = 1'b0;
    send_bits(8'hFF, 7, 1'b1);
    send_word(8'h96, -1, -1, 1'b0);
    check_eq("t5_last_resync_pout", 32'(pout_l), 32'h96);
    check_eq("t5_last_resync_ovr",  32'(ovr_l),  32'h0);
    out_ready = 1'b1;
    step();
    check_eq("t5_valid_drop", 32'(valid_l), 32'h0);
    // HUNT ignores unframed bits
    send_bits(8'hFF, 8, 1'b0);
    check_eq("t5_hunt_valid", 32'(valid_l), 32'h0);
    check_eq("t5_hunt_busy",  32'(busy_l),  32'h0);
    check_eq("t5_hunt_pout",  32'(pout_l),  32'h96);

    // 6: async reset mid-frame with a pending word
    out_ready = 1'b0;
    send_word(8'h3C, -1, -1, 1'b0);
    send_bits(8'h1F, 5, 1'b1);
    check_eq("t6_busy_pre", 32'(busy_l), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_pout",   32'(pout_l),  32'h0);
    check_eq("t6_rst_valid",  32'(valid_l), 32'h0);
    check_eq("t6_rst_ovr",    32'(ovr_l),   32'h0);
    check_eq("t6_rst_busy",   32'(busy_l),  32'h0);
    check_eq("t6_rst_pout_m", 32'(pout_m),  32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    send_word(8'h81, -1, -1, 1'b0);
    check_eq("t6_pout",   32'(pout_l),  32'h81);
    check_eq("t6_valid",  32'(valid_l), 32'h1);
    check_eq("t6_pout_m", 32'(pout_m),  32'h81);
    out_ready = 1'b1;
    step();
    // serial order 1,0,0,0,0,0,1,1
    send_word(8'hC1, -1, -1, 1'b1);
    check_eq("t6_msb_pout",  32'(pout_m),  32'h83);
    check_eq("t6_msb_valid", 32'(valid_m), 32'h1);
    check_eq("t6_lsb_pout",  32'(pout_l),  32'hC1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
